riscv_soft_wb_arbiter: RTL and testbench
========================================

// Module: riscv_soft_wb_arbiter
// PURPOSE
//  Owns the single write port of riscv_soft_regfile; shares it between two writers:
//  - single-cycle execute path (EX): priority writer, no backpressure
//  - long-latency path (LL: loads, mul/div): valid/ready, buffered in a small FIFO
//  Keeps a 32-entry busy scoreboard so issue logic can stall on pending LL destinations.
// PARAMETERS
//  XPR_LEN      32  data width, matches regfile
//  LQ_DEPTH     2   LL result FIFO entries (>=1)
//  STARVE_LIMIT 4   consecutive cycles an LL entry may wait before ex_stall asserts (>=1)
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  reset_n      in   1        asynchronous, active-low reset
//  ex_wr_en     in   1        EX writeback valid this cycle
//  ex_wr_addr   in   5        EX destination register
//  ex_wr_data   in   XPR_LEN  EX result
//  ex_stall     out  1        registered; asks upstream to withhold ex_wr_en
//  ll_issue     in   1        LL op issued this cycle; mark ll_issue_rd busy
//  ll_issue_rd  in   5        LL op destination
//  ll_valid     in   1        LL result offered
//  ll_ready     out  1        = FIFO not full (combinational from state only)
//  ll_rd        in   5        LL result destination
//  ll_data      in   XPR_LEN  LL result
//  hz_addr_1    in   5        scoreboard lookup address 1
//  hz_busy_1    out  1        busy[hz_addr_1], combinational
//  hz_addr_2    in   5        scoreboard lookup address 2
//  hz_busy_2    out  1        busy[hz_addr_2], combinational
//  rf_wr_en     out  1        registered regfile write enable
//  rf_wr_addr   out  5        registered regfile write address
//  rf_wr_data   out  XPR_LEN  registered regfile write data
// BEHAVIOUR
//  - Reset (async, reset_n=0): busy=0, FIFO empty, starve count=0, rf_wr_en=0,
//    rf_wr_addr=0, rf_wr_data=0, ex_stall=0, rf_src_ll=0. In-flight LL data discarded.
//  - FIFO push: ll_valid&&ll_ready&&ll_rd!=0. ll_rd==0 handshakes complete, data dropped.
//    Full FIFO refuses push even if popping same cycle. Pointers wrap modulo LQ_DEPTH.
//  - Arbitration per cycle: ex_wr_en=1 -> EX selected (regardless of ex_stall);
//    else FIFO non-empty -> head popped and selected; else nothing.
//  - Selected write registered: rf_wr_* valid next cycle (latency 1); rf_src_ll records
//    source. EX write to addr 0 still drives rf_wr_en (regfile ignores x0 on read).
//  - Scoreboard: busy[r] set at edge when ll_issue && ll_issue_rd==r && r!=0;
//    cleared at edge when rf_wr_en && rf_src_ll && rf_wr_addr==r (same edge regfile
//    writes). Set and clear of same r same edge: set wins. busy[0] always 0.
//    hz_busy_k goes 0 the cycle the new value is readable from regfile (no bypass).
//  - Starvation: count increments each cycle FIFO non-empty and no pop; resets to 0 on
//    pop or empty; saturates. ex_stall <= (count >= STARVE_LIMIT-1) && !pop_this_cycle.
//    Upstream must drop ex_wr_en while ex_stall=1; if it does not, EX still wins
//    (never dropped) and ex_stall stays high.
//  - Illegal, checked by assertion only: ll_issue to an rd already busy;
//    ex_wr_en to a busy rd; ll_valid with ll_rd not busy.
// STRUCTURE
//  - Shared header riscv_soft_defs.vh: REG_ADDR_W=5, NUM_REGS=32, XPR_LEN default.
//  - Sub-module riscv_soft_wb_fifo: parameterised sync FIFO (width 5+XPR_LEN, depth
//    LQ_DEPTH) with push/pop/full/empty/head; async active-low reset.
//  - Top: arbiter mux, output registers, busy vector, starve counter.
// TESTING
//  1 EX only: ex_wr_en=1 addr=5 data=0x1234 -> next cycle rf_wr_en=1 addr=5 data=0x1234.
//  2 LL: ll_issue rd=7 -> hz_busy(7)=1; ll_valid rd=7 data=0xBEEF idle EX -> rf write
//    rd=7 two cycles after handshake edge; hz_busy(7)=0 the following cycle.
//  3 Conflict: EX and LL valid every cycle -> EX wins; ll_ready=0 after 2 pushes;
//    ex_stall=1 after 4 unserved cycles; drop ex_wr_en -> FIFO drains oldest-first.
//  4 Same-edge set/clear: LL write to r3 retires while ll_issue rd=3 -> busy(3) stays 1.
//  5 ll_rd=0 and ll_issue_rd=0 -> handshake completes, no rf write, busy(0)=0.
//  6 reset_n low mid-drain with FIFO full -> outputs 0 immediately, ll_ready=1 after.

Source files
------------

// File: rtl/riscv_soft_wb_arbiter_pkg.sv
// Shared register-file geometry and writeback helpers for the soft RISC-V core.
// Imported by the writeback arbiter and its result FIFO.
package riscv_soft_wb_arbiter_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 32;
    localparam int XPR_LEN_DEF = 32;

    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_LL = 1'b1
    } wb_src_e;

    // One-hot mask for a register, with x0 forced out so it can never be marked busy.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        m[0]    = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/riscv_soft_wb_fifo.sv
// Small synchronous FIFO holding long-latency writeback results ({rd, data}).
// Push while full and pop while empty are ignored.
module riscv_soft_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_soft_wb_arbiter.sv
// Regfile write-port arbiter: EX path has priority, long-latency results queue in a FIFO,
// and a busy scoreboard tracks LL destinations until their value lands in the regfile.
module riscv_soft_wb_arbiter
    import riscv_soft_wb_arbiter_pkg::*;
#(
    parameter int XPR_LEN      = XPR_LEN_DEF,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic [XPR_LEN-1:0]    ex_wr_data,
    output logic                  ex_stall,
    input  logic                  ll_issue,
    input  logic [REG_ADDR_W-1:0] ll_issue_rd,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XPR_LEN-1:0]    ll_data,
    input  logic [REG_ADDR_W-1:0] hz_addr_1,
    output logic                  hz_busy_1,
    input  logic [REG_ADDR_W-1:0] hz_addr_2,
    output logic                  hz_busy_2,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XPR_LEN-1:0]    rf_wr_data
);

    localparam int ENTRY_W = REG_ADDR_W + XPR_LEN;
    localparam int CNT_W   = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [CNT_W-1:0]   starve_cnt;
    wb_src_e            rf_src;

    // Writes to x0 from the LL path complete the handshake but never occupy the queue.
    assign ll_ready  = !fifo_full;
    assign fifo_push = ll_valid && ll_ready && (ll_rd != '0);
    assign fifo_pop  = !ex_wr_en && !fifo_empty;

    riscv_soft_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({ll_rd, ll_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Busy clears on the same edge the regfile absorbs the LL write, so no bypass is needed.
    assign set_mask  = ll_issue ? reg_mask(ll_issue_rd) : '0;
    assign clr_mask  = (rf_wr_en && (rf_src == SRC_LL)) ? reg_mask(rf_wr_addr) : '0;
    assign hz_busy_1 = busy[hz_addr_1];
    assign hz_busy_2 = busy[hz_addr_2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            rf_src     <= SRC_EX;
        end else if (ex_wr_en) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= ex_wr_addr;
            rf_wr_data <= ex_wr_data;
            rf_src     <= SRC_EX;
        end else if (fifo_pop) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= fifo_head[ENTRY_W-1 -: REG_ADDR_W];
            rf_wr_data <= fifo_head[XPR_LEN-1:0];
            rf_src     <= SRC_LL;
        end else begin
            rf_wr_en   <= 1'b0;
            rf_src     <= SRC_EX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // Stall asks EX to yield once the queued head has waited STARVE_LIMIT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            ex_stall   <= 1'b0;
        end else begin
            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            ex_stall <= !fifo_empty && !fifo_pop && (starve_cnt >= CNT_MAX);
        end
    end

    a_issue_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
        ll_issue |-> !(busy[ll_issue_rd] && !clr_mask[ll_issue_rd]));
    a_ex_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
        ex_wr_en |-> !busy[ex_wr_addr]);
    a_ll_result_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (ll_valid && (ll_rd != '0)) |-> busy[ll_rd]);

endmodule

// File: tb/tb_riscv_soft_wb_arbiter.sv
// Self-checking bench for riscv_soft_wb_arbiter: directed scenarios followed by
// constrained-random traffic compared against a queue-based reference model.
module tb_riscv_soft_wb_arbiter;

    localparam int XPR_LEN      = 32;
    localparam int LQ_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        ex_stall;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic [4:0]  hz_addr_1;
    logic        hz_busy_1;
    logic [4:0]  hz_addr_2;
    logic        hz_busy_2;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    riscv_soft_wb_arbiter #(
        .XPR_LEN      (XPR_LEN),
        .LQ_DEPTH     (LQ_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ex_wr_en    (ex_wr_en),
        .ex_wr_addr  (ex_wr_addr),
        .ex_wr_data  (ex_wr_data),
        .ex_stall    (ex_stall),
        .ll_issue    (ll_issue),
        .ll_issue_rd (ll_issue_rd),
        .ll_valid    (ll_valid),
        .ll_ready    (ll_ready),
        .ll_rd       (ll_rd),
        .ll_data     (ll_data),
        .hz_addr_1   (hz_addr_1),
        .hz_busy_1   (hz_busy_1),
        .hz_addr_2   (hz_addr_2),
        .hz_busy_2   (hz_busy_2),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_entry_t;

    // Reference model: pending LL results, busy set, head wait time, registered rf write.
    ll_entry_t   m_q[$];
    bit          m_busy[32];
    int          m_wait;
    bit          m_stall;
    bit          m_rf_en;
    bit          m_rf_ll;
    logic [4:0]  m_rf_addr;
    logic [31:0] m_rf_data;
    logic [4:0]  outstanding[$];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wait    = 0;
        m_stall   = 1'b0;
        m_rf_en   = 1'b0;
        m_rf_ll   = 1'b0;
        m_rf_addr = '0;
        m_rf_data = '0;
    endtask

    task automatic modelStep();
        bit        was_full;
        bit        pop;
        ll_entry_t e;
        was_full = (m_q.size() >= LQ_DEPTH);
        pop      = !ex_wr_en && (m_q.size() > 0);
        if (m_rf_en && m_rf_ll) m_busy[m_rf_addr] = 1'b0;
        if (ll_issue && ll_issue_rd != 5'd0) m_busy[ll_issue_rd] = 1'b1;
        if (m_q.size() > 0 && !pop) begin
            m_stall = (m_wait >= STARVE_LIMIT - 1);
            m_wait++;
        end else begin
            m_stall = 1'b0;
            m_wait  = 0;
        end
        if (ex_wr_en) begin
            m_rf_en   = 1'b1;
            m_rf_ll   = 1'b0;
            m_rf_addr = ex_wr_addr;
            m_rf_data = ex_wr_data;
        end else if (pop) begin
            e         = m_q.pop_front();
            m_rf_en   = 1'b1;
            m_rf_ll   = 1'b1;
            m_rf_addr = e.rd;
            m_rf_data = e.data;
        end else begin
            m_rf_en = 1'b0;
            m_rf_ll = 1'b0;
        end
        if (ll_valid && !was_full && ll_rd != 5'd0) begin
            e.rd   = ll_rd;
            e.data = ll_data;
            m_q.push_back(e);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check against the model, advance the model.
    task automatic applyStimulus(input bit exe, input logic [4:0] exa, input logic [31:0] exd,
                                 input bit iss, input logic [4:0] issrd,
                                 input bit llv, input logic [4:0] llrd, input logic [31:0] lld,
                                 input logic [4:0] h1, input logic [4:0] h2);
        @(negedge clk);
        ex_wr_en    = exe;
        ex_wr_addr  = exa;
        ex_wr_data  = exd;
        ll_issue    = iss;
        ll_issue_rd = issrd;
        ll_valid    = llv;
        ll_rd       = llrd;
        ll_data     = lld;
        hz_addr_1   = h1;
        hz_addr_2   = h2;
        #1;
        checkOutput("ll_ready", ll_ready, m_q.size() < LQ_DEPTH);
        checkOutput("hz_busy_1", hz_busy_1, m_busy[h1]);
        checkOutput("hz_busy_2", hz_busy_2, m_busy[h2]);
        checkOutput("rf_wr_en", rf_wr_en, m_rf_en);
        if (m_rf_en) begin
            checkOutput("rf_wr_addr", rf_wr_addr, m_rf_addr);
            checkOutput("rf_wr_data", rf_wr_data, m_rf_data);
        end
        checkOutput("ex_stall", ex_stall, m_stall);
        modelStep();
    endtask

    task automatic idle(input logic [4:0] h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, h1, 0);
    endtask

    initial begin
        reset_n     = 1'b1;
        ex_wr_en    = 1'b0;
        ex_wr_addr  = '0;
        ex_wr_data  = '0;
        ll_issue    = 1'b0;
        ll_issue_rd = '0;
        ll_valid    = 1'b0;
        ll_rd       = '0;
        ll_data     = '0;
        hz_addr_1   = '0;
        hz_addr_2   = '0;
        modelReset();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_rf_wr_en", rf_wr_en, 1'b0);
        checkOutput("rst_rf_wr_addr", rf_wr_addr, 5'd0);
        checkOutput("rst_rf_wr_data", rf_wr_data, 32'd0);
        checkOutput("rst_ex_stall", ex_stall, 1'b0);
        checkOutput("rst_ll_ready", ll_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // EX-only write appears one cycle later.
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        checkOutput("t1_rf_wr_en", rf_wr_en, 1'b1);
        checkOutput("t1_rf_wr_addr", rf_wr_addr, 5'd5);
        checkOutput("t1_rf_wr_data", rf_wr_data, 32'h1234);

        // LL result to r7: busy until the regfile write edge.
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'hBEEF, 7, 0);
        checkOutput("t2_busy_set", hz_busy_1, 1'b1);
        idle(7);
        idle(7);
        checkOutput("t2_rf_wr_en", rf_wr_en, 1'b1);
        checkOutput("t2_rf_wr_addr", rf_wr_addr, 5'd7);
        checkOutput("t2_rf_wr_data", rf_wr_data, 32'hBEEF);
        checkOutput("t2_busy_hold", hz_busy_1, 1'b1);
        idle(7);
        checkOutput("t2_busy_clear", hz_busy_1, 1'b0);

        // x0 traffic: handshake only, nothing written or marked.
        idle(0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 32'hDEAD, 0, 0);
        checkOutput("t5_ready", ll_ready, 1'b1);
        idle(0);
        checkOutput("t5_no_write", rf_wr_en, 1'b0);
        checkOutput("t5_busy0", hz_busy_1, 1'b0);
        idle(0);
        checkOutput("t5_no_write2", rf_wr_en, 1'b0);

        // Retire of r3 coincides with a fresh issue to r3: busy must stay set.
        applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 3, 0);
        idle(3);
        applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 3, 0);
        checkOutput("t4_retire_en", rf_wr_en, 1'b1);
        checkOutput("t4_retire_addr", rf_wr_addr, 5'd3);
        idle(3);
        checkOutput("t4_busy_kept", hz_busy_1, 1'b1);

        // EX hogs the port: queue fills, stall raises, then the queue drains in order.
        applyStimulus(0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        applyStimulus(1, 20, 32'h2001, 0, 0, 1, 8, 32'h108, 8, 9);
        applyStimulus(1, 20, 32'h2002, 0, 0, 1, 9, 32'h109, 8, 9);
        applyStimulus(1, 20, 32'h2003, 0, 0, 1, 10, 32'h10A, 8, 9);
        checkOutput("t3_full", ll_ready, 1'b0);
        applyStimulus(1, 20, 32'h2004, 0, 0, 1, 10, 32'h10A, 8, 9);
        applyStimulus(1, 20, 32'h2005, 0, 0, 1, 10, 32'h10A, 8, 9);
        applyStimulus(1, 20, 32'h2006, 0, 0, 1, 10, 32'h10A, 8, 9);
        checkOutput("t3_stall", ex_stall, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 10, 32'h10A, 8, 9);
        checkOutput("t3_stall_held", ex_stall, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 10, 32'h10A, 8, 9);
        checkOutput("t3_drain1_addr", rf_wr_addr, 5'd8);
        checkOutput("t3_drain1_data", rf_wr_data, 32'h108);
        idle(10);
        checkOutput("t3_drain2_addr", rf_wr_addr, 5'd9);
        idle(10);
        checkOutput("t3_drain3_addr", rf_wr_addr, 5'd10);
        checkOutput("t3_drain3_data", rf_wr_data, 32'h10A);

        // Asynchronous reset while the queue is full and draining.
        applyStimulus(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        applyStimulus(1, 21, 32'h3001, 0, 0, 1, 12, 32'h10C, 12, 13);
        applyStimulus(1, 21, 32'h3002, 0, 0, 1, 13, 32'h10D, 12, 13);
        @(negedge clk);
        ex_wr_en  = 1'b0;
        ll_valid  = 1'b0;
        hz_addr_1 = 5'd12;
        #1;
        checkOutput("t6_full_pre", ll_ready, 1'b0);
        checkOutput("t6_wr_pre", rf_wr_en, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_rf_wr_en", rf_wr_en, 1'b0);
        checkOutput("t6_rf_wr_addr", rf_wr_addr, 5'd0);
        checkOutput("t6_rf_wr_data", rf_wr_data, 32'd0);
        checkOutput("t6_ex_stall", ex_stall, 1'b0);
        checkOutput("t6_ll_ready", ll_ready, 1'b1);
        checkOutput("t6_busy", hz_busy_1, 1'b0);
        modelReset();
        outstanding.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // Random legal traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          e;
            bit          iss;
            bit          v;
            bit          acc;
            int          idx;
            logic [4:0]  ea;
            logic [4:0]  ir;
            logic [4:0]  vr;
            ea  = 5'($urandom_range(0, 31));
            e   = ($urandom_range(0, 1) == 1) && !m_busy[ea];
            if (m_stall && $urandom_range(0, 3) != 0) e = 1'b0;
            ir  = 5'($urandom_range(0, 31));
            iss = ($urandom_range(0, 2) == 0) && !m_busy[ir];
            v   = 1'b0;
            vr  = '0;
            idx = -1;
            if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, outstanding.size() - 1);
                vr  = outstanding[idx];
                v   = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                v = 1'b1;
            end
            acc = v && (m_q.size() < LQ_DEPTH);
            applyStimulus(e, ea, $urandom, iss, ir, v, vr, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (acc && idx >= 0) outstanding.delete(idx);
            if (iss && ir != 5'd0) outstanding.push_back(ir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
